des_iter_ctrl: RTL and testbench
================================

DES_ITER_CTRL -- requirements
Module: des_iter_ctrl

Interface
REQ-001 Parameters: none; round count (16) and DES tables are fixed constants.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to process one 64-bit block; sampled only while ready=1.
REQ-005 mode  input  1  0 = encrypt, 1 = decrypt; sampled with start.
REQ-006 key  input  64  DES key including parity bits; sampled with start.
REQ-007 data_in  input  64  plaintext/ciphertext block; sampled with start.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 done  output  1  one-cycle pulse when data_out holds a new result.
REQ-010 data_out  output  64  result block; holds its value until the next result or reset.
REQ-011 rnd_subkey  output  48  subkey to round datapath.
REQ-012 rnd_in_left, rnd_in_right  output  32 each  round datapath inputs.
REQ-013 rnd_out_left, rnd_out_right  input  32 each  registered round outputs (1-cycle latency, same clk/rst).

Function
REQ-014 States SHALL be IDLE, ROUND, FINISH, with 4-bit round counter cnt.
REQ-015 IDLE & start=1 SHALL latch {L0,R0}=IP(data_in), C/D from PC1(key), mode; set cnt=0; go to ROUND.
REQ-016 IDLE & start=0 SHALL stay in IDLE; start outside IDLE SHALL be ignored, not queued.
REQ-017 In ROUND, rnd_in_left/right SHALL be L0/R0 when cnt=0, else rnd_out_left/right.
REQ-018 rnd_subkey SHALL be PC2(C,D) of the current C/D registers; outside ROUND it SHALL be 0.
REQ-019 Shift table S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (rounds 1..16).
REQ-020 Encrypt: at load C/D = rotl(PC1 halves, S[1]); after round i (cnt=i-1), C/D rotl by S[i+1], i<16.
REQ-021 Decrypt: at load C/D = PC1 halves unrotated (K16); after decrypt step j (cnt=j-1), C/D rotr by S[17-j], j<16.
REQ-022 ROUND SHALL increment cnt each cycle; at cnt=15 go to FINISH (16 round cycles total).
REQ-023 FINISH SHALL register data_out = FP({rnd_out_right, rnd_out_left}) (final swap), pulse done, return to IDLE.
REQ-024 Latency: start sampled at edge E0 -> done high in the cycle after edge E17; ready re-asserts in that same cycle.
REQ-025 Back-to-back: start held high while done=1 SHALL be accepted in that cycle; throughput one block per 18 cycles.
REQ-026 All rotations are 28-bit modular; cnt never wraps past 15 in ROUND.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE, cnt=0, done=0, data_out=0, C/D/L0/R0=0, aborting any block in flight.
REQ-028 First cycle after rst deasserts: ready=1; a start in that cycle SHALL be accepted.
REQ-029 An aborted block SHALL never produce done.

Structure
REQ-030 Shared include des_defs.vh SHALL hold IP, FP, PC1, PC2, shift table S, state encodings.
REQ-031 Key rotation and PC2 SHALL live in one sub-module des_key_sched (load, step, mode inputs; subkey output).
REQ-032 Controller SHALL NOT instantiate the round datapath; the bench/top connects it via rnd_* ports.

Verification
REQ-033 Encrypt key 133457799BBCDFF1, data 0123456789ABCDEF -> data_out 85E813540F0AB405, done 17 cycles after start accepted.
REQ-034 Decrypt same key, data 85E813540F0AB405 -> data_out 0123456789ABCDEF.
REQ-035 Encrypt key 0E329232EA6D0D73, data 8787878787878787 -> 0000000000000000; round-1 subkey checked = PC2(rotl1(PC1(key))).
REQ-036 rst pulsed at cnt=7 -> no done, data_out=0, ready=1 next cycle; following block correct.
REQ-037 start held high continuously, two blocks -> both results correct, done pulses 18 cycles apart; start pulses during ROUND ignored.

Source files
------------

// File: rtl/des_iter_ctrl_pkg.sv
// Shared DES constants for the iterative controller: state encoding, IP/FP/PC1/PC2
// tables, the key shift schedule, and the permutation/rotation helpers built on them.
package des_iter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int NUM_ROUNDS = 16;

    // Tables use DES numbering: entry value 1 is the MSB of the source word.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };

    // Left-shift amount for rounds 1..16 (index 0 = round 1).
    localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
        return (x >> n) | (x << (28 - n));
    endfunction

endpackage

// File: rtl/des_key_sched.sv
// DES key schedule: holds the C/D halves, rotates them once per round in the
// direction set by the latched mode, and presents PC2(C,D) as the round subkey.
module des_key_sched
    import des_iter_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        mode,
    input  logic [63:0] key,
    input  logic [3:0]  cnt,
    output logic [47:0] subkey
);

    logic [27:0] c;
    logic [27:0] d;
    logic        mode_q;
    logic [55:0] pc1;

    always_comb begin
        pc1    = pc1_perm(key);
        subkey = pc2_perm({c, d});
    end

    // Encrypt loads K1's halves (pre-rotated); decrypt loads K16's halves, which
    // equal PC1 unrotated because the 16 shifts sum to a full 28-bit turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            c      <= '0;
            d      <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            mode_q <= mode;
            if (mode) begin
                c <= pc1[55:28];
                d <= pc1[27:0];
            end else begin
                c <= rotl28(pc1[55:28], SHIFT_T[0]);
                d <= rotl28(pc1[27:0], SHIFT_T[0]);
            end
        end else if (step) begin
            if (mode_q) begin
                c <= rotr28(c, SHIFT_T[4'd15 - cnt]);
                d <= rotr28(d, SHIFT_T[4'd15 - cnt]);
            end else begin
                c <= rotl28(c, SHIFT_T[cnt + 4'd1]);
                d <= rotl28(d, SHIFT_T[cnt + 4'd1]);
            end
        end
    end

endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative DES controller: sequences 16 rounds through an external registered
// round datapath, supplies subkeys, and applies IP/FP around the block.
module des_iter_ctrl
    import des_iter_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [63:0] key,
    input  logic [63:0] data_in,
    output logic        ready,
    output logic        done,
    output logic [63:0] data_out,
    output logic [47:0] rnd_subkey,
    output logic [31:0] rnd_in_left,
    output logic [31:0] rnd_in_right,
    input  logic [31:0] rnd_out_left,
    input  logic [31:0] rnd_out_right
);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [31:0] l0;
    logic [31:0] r0;
    logic        load;
    logic        step;
    logic        finish;
    logic [47:0] subkey;

    des_key_sched u_key_sched (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .mode   (mode),
        .key    (key),
        .cnt    (cnt),
        .subkey (subkey)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ROUND;
                    load      = 1'b1;
                end
            end
            ST_ROUND: begin
                if (cnt == 4'(NUM_ROUNDS - 1)) state_nxt = ST_FINISH;
                else                           step      = 1'b1;
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
                finish    = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            l0       <= '0;
            r0       <= '0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            state <= state_nxt;
            done  <= finish;
            if (load) begin
                {l0, r0} <= ip_perm(data_in);
                cnt      <= '0;
            end else if (step) begin
                cnt <= cnt + 4'd1;
            end
            // The last round leaves (L16,R16); DES output is FP(R16,L16).
            if (finish) data_out <= fp_perm({rnd_out_right, rnd_out_left});
        end
    end

    always_comb begin
        ready        = (state == ST_IDLE);
        rnd_subkey   = (state == ST_ROUND) ? subkey : '0;
        rnd_in_left  = (cnt == 4'd0) ? l0 : rnd_out_left;
        rnd_in_right = (cnt == 4'd0) ? r0 : rnd_out_right;
    end

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Bench for des_iter_ctrl: supplies a registered DES round datapath and checks
// results against published DES vectors through a done-driven scoreboard.
module tb_des_iter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [63:0] key;
    logic [63:0] data_in;
    logic        ready;
    logic        done;
    logic [63:0] data_out;
    logic [47:0] rnd_subkey;
    logic [31:0] rnd_in_left;
    logic [31:0] rnd_in_right;
    logic [31:0] rnd_out_left;
    logic [31:0] rnd_out_right;

    always #5 clk = ~clk;

    des_iter_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .key           (key),
        .data_in       (data_in),
        .ready         (ready),
        .done          (done),
        .data_out      (data_out),
        .rnd_subkey    (rnd_subkey),
        .rnd_in_left   (rnd_in_left),
        .rnd_in_right  (rnd_in_right),
        .rnd_out_left  (rnd_out_left),
        .rnd_out_right (rnd_out_right)
    );

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2  = 64'h8787878787878787;
    localparam logic [63:0] CT2  = 64'h0000000000000000;

    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,  16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1
    };

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9,  19, 13, 30, 6, 22, 11, 4, 25
    };

    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  b;
        int          row;
        int          col;
        e = '0;
        s = '0;
        p = '0;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            b   = e[47-6*j -: 6];
            row = {30'd0, b[5], b[0]};
            col = {28'd0, b[4:1]};
            s[31-4*j -: 4] = 4'(SBOX[j][row*16+col]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    // Registered round datapath: one Feistel round per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_out_left  <= '0;
            rnd_out_right <= '0;
        end else begin
            rnd_out_left  <= rnd_in_right;
            rnd_out_right <= rnd_in_left ^ f_func(rnd_in_right, rnd_subkey);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every done pulse must match the oldest outstanding block.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("done_without_block", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", data_out, e.data);
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge while the DUT is idle: accept happens at the next edge,
    // done is due 17 edges after that.
    task automatic issue(input logic m, input logic [63:0] k, input logic [63:0] d,
                         input logic [63:0] exp);
        start   = 1'b1;
        mode    = m;
        key     = k;
        data_in = d;
        sb.push_back('{data: exp, cyc: cyc + 18});
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        key     = '0;
        data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_subkey", 64'(rnd_subkey), 64'd0);

        // Encrypt classic vector, probing rounds 1 and 2.
        issue(1'b0, KEY1, PT1, CT1);
        @(negedge clk);
        start = 1'b0;
        chk("enc_busy_ready", 64'(ready), 64'd0);
        chk("enc_k1", 64'(rnd_subkey), 64'h1B02EFFC7072);
        chk("enc_l0", 64'(rnd_in_left), 64'hCC00CCFF);
        chk("enc_r0", 64'(rnd_in_right), 64'hF0AAF0AA);
        @(negedge clk);
        chk("enc_k2", 64'(rnd_subkey), 64'h79AED9DBC9E5);
        chk("enc_l1", 64'(rnd_in_left), 64'hF0AAF0AA);
        chk("enc_r1", 64'(rnd_in_right), 64'hEF4A6544);
        drain(40);
        repeat (3) @(negedge clk);
        chk("data_out_hold", data_out, CT1);
        chk("idle_subkey", 64'(rnd_subkey), 64'd0);

        // Decrypt back to the plaintext; first subkey is K16.
        issue(1'b1, KEY1, CT1, PT1);
        @(negedge clk);
        start = 1'b0;
        chk("dec_k16", 64'(rnd_subkey), 64'hCB3D8B0E17F5);
        drain(40);

        // Second key, all-zero ciphertext.
        @(negedge clk);
        issue(1'b0, KEY2, PT2, CT2);
        @(negedge clk);
        start = 1'b0;
        chk("key2_k1", 64'(rnd_subkey), 64'h36146478E1E1);
        drain(40);

        // Abort mid-block, then start again in the first cycle out of reset.
        @(negedge clk);
        issue(1'b0, KEY2, PT2, CT2);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_data_out", data_out, 64'd0);
        chk("abort_subkey", 64'(rnd_subkey), 64'd0);
        issue(1'b0, KEY1, PT1, CT1);
        @(negedge clk);
        start = 1'b0;
        drain(40);

        // Back-to-back with start held high; mid-block input changes must be ignored.
        @(negedge clk);
        issue(1'b0, KEY1, PT1, CT1);
        @(negedge clk);
        key     = KEY2;
        data_in = PT2;
        sb.push_back('{data: CT2, cyc: cyc + 35});
        repeat (18) @(negedge clk);
        start = 1'b0;
        chk("b2b_second_accepted", 64'(ready), 64'd0);
        drain(60);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
